// File: rtl/stopwatch_if.sv
// Stopwatch controller bundle: button/switch inputs in, datapath and display controls out.
interface stopwatch_if;
  logic       pause_p;
  logic       adj;
  logic       sel;
  logic       inc_sec;
  logic       inc_min;
  logic       carry_en;
  logic       scan_tick;
  logic [1:0] digit_idx;
  logic       blank_sec;
  logic       blank_min;
  logic [1:0] mode;

  modport master (
    output pause_p, adj, sel,
    input  inc_sec, inc_min, carry_en, scan_tick, digit_idx, blank_sec, blank_min, mode
  );

  modport slave (
    input  pause_p, adj, sel,
    output inc_sec, inc_min, carry_en, scan_tick, digit_idx, blank_sec, blank_min, mode
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch timing/mode controller: clock-enable time bases from one clock plus the
// RUN/PAUSE/ADJ mode FSM driving the counter datapath and the display scanner.
module stopwatch_ctrl #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 500,
  parameter int BLINK_HZ = 4
) (
  input  logic       clk,
  input  logic       rst,
  stopwatch_if.slave sw
);
  localparam int HALF_DIV  = CLK_HZ / 2;
  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF_W    = (HALF_DIV  > 1) ? $clog2(HALF_DIV)  : 1;
  localparam int SCAN_W    = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAUSE = 2'd1,
    S_ADJ   = 2'd2
  } state_t;

  logic [HALF_W-1:0]  cnt2;
  logic [SCAN_W-1:0]  cnts;
  logic [BLINK_W-1:0] cntb;
  logic               half;
  logic               blink_on;
  logic               tick2, tick1, scan_wrap, blink_wrap;
  logic               scan_tick_q;
  logic [1:0]         digit_idx_q;

  state_t state, state_nxt;
  logic   paused, paused_nxt;
  logic   inc_sec_q, inc_min_q, carry_en_q, blank_sec_q, blank_min_q;
  logic   inc_sec_d, inc_min_d, carry_en_d, blank_sec_d, blank_min_d;

  assign tick2      = (cnt2 == HALF_W'(HALF_DIV - 1));
  assign tick1      = tick2 & half;
  assign scan_wrap  = (cnts == SCAN_W'(SCAN_DIV - 1));
  assign blink_wrap = (cntb == BLINK_W'(BLINK_DIV - 1));

  // Time bases free-run in every mode; only reset realigns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt2        <= '0;
      cnts        <= '0;
      cntb        <= '0;
      half        <= 1'b0;
      blink_on    <= 1'b1;
      scan_tick_q <= 1'b0;
      digit_idx_q <= 2'd0;
    end else begin
      cnt2        <= tick2 ? '0 : cnt2 + 1'b1;
      cnts        <= scan_wrap ? '0 : cnts + 1'b1;
      cntb        <= blink_wrap ? '0 : cntb + 1'b1;
      scan_tick_q <= scan_wrap;
      if (tick2)      half        <= ~half;
      if (blink_wrap) blink_on    <= ~blink_on;
      if (scan_wrap)  digit_idx_q <= digit_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      paused      <= 1'b0;
      inc_sec_q   <= 1'b0;
      inc_min_q   <= 1'b0;
      carry_en_q  <= 1'b1;
      blank_sec_q <= 1'b0;
      blank_min_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      paused      <= paused_nxt;
      inc_sec_q   <= inc_sec_d;
      inc_min_q   <= inc_min_d;
      carry_en_q  <= carry_en_d;
      blank_sec_q <= blank_sec_d;
      blank_min_q <= blank_min_d;
    end
  end

  // Strobes and blanking are judged by the current registered state, so a tick that
  // lands on a mode-change edge follows the old mode; carry_en tracks the new mode.
  always_comb begin
    paused_nxt  = paused ^ sw.pause_p;
    state_nxt   = S_RUN;
    inc_sec_d   = 1'b0;
    inc_min_d   = 1'b0;
    blank_sec_d = 1'b0;
    blank_min_d = 1'b0;
    if (sw.adj)          state_nxt = S_ADJ;
    else if (paused_nxt) state_nxt = S_PAUSE;
    carry_en_d = (state_nxt != S_ADJ);
    unique case (state)
      S_RUN: inc_sec_d = tick1;
      S_ADJ: begin
        inc_sec_d   = tick2 & ~sw.sel;
        inc_min_d   = tick2 &  sw.sel;
        blank_sec_d = ~sw.sel & ~blink_on;
        blank_min_d =  sw.sel & ~blink_on;
      end
      default: ;
    endcase
  end

  assign sw.inc_sec   = inc_sec_q;
  assign sw.inc_min   = inc_min_q;
  assign sw.carry_en  = carry_en_q;
  assign sw.scan_tick = scan_tick_q;
  assign sw.digit_idx = digit_idx_q;
  assign sw.blank_sec = blank_sec_q;
  assign sw.blank_min = blank_min_q;
  assign sw.mode      = state;
endmodule
